codec_intf: RTL and testbench

- I2S master interface between the external audio codec and the equalizer engine.
- Generates the codec clocks (MCLK, SCLK, LRCLK) and the codec reset.
- Deserializes the codec ADC stream into 16-bit left/right samples and presents them with a one-cycle vld strobe; this is the engine's aud_in/vld source.
- Serializes the engine's processed samples back to the codec DAC.

---
 rtl/codec_pkg.sv | 21 ++
 rtl/codec_clk_gen.sv | 39 +++
 rtl/codec_intf.sv | 131 +++++++++++++
 tb/tb_codec_intf.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// Shared state type and frame-timing constants for the I2S codec interface.
package codec_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [3:0] SMPL_PH    = 4'd7;
  localparam logic [3:0] SHFT_PH    = 4'd15;
  localparam logic [9:0] LFT_DONE   = 10'd263;
  localparam logic [9:0] VLD_CNT    = 10'd776;
  localparam logic [4:0] FIRST_SLOT = 5'd1;
  localparam logic [4:0] LAST_SLOT  = 5'd16;

  function automatic logic slot_in(input logic [4:0] slot, input logic [4:0] last);
    return (slot >= FIRST_SLOT) && (slot <= last);
  endfunction

endpackage

// File: rtl/codec_clk_gen.sv
// Free-running frame counter producing MCLK/SCLK/LRCLK, the bit slot and the sample/shift strobes.
module codec_clk_gen
  import codec_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic [4:0]       slot,
  output logic             mclk,
  output logic             sclk,
  output logic             lrclk,
  output logic             smpl_stb,
  output logic             shft_stb,
  output logic             frame_end
);

  logic [CNT_W-1:0] cnt_r;

  // Frame counter, wraps to zero after the last cycle of the LRCLK frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt       = cnt_r;
  assign slot      = cnt_r[CNT_W-2 -: 5];
  assign mclk      = cnt_r[1];
  assign sclk      = cnt_r[3];
  assign lrclk     = cnt_r[CNT_W-1];
  assign smpl_stb  = (cnt_r[3:0] == SMPL_PH);
  assign shft_stb  = (cnt_r[3:0] == SHFT_PH);
  assign frame_end = &cnt_r;

endmodule

// File: rtl/codec_intf.sv
// I2S master between the audio codec and the EQ engine: clocks, codec reset, ADC capture, DAC serialize.
// Define CODEC_LOOPBACK_EN to feed the serial DAC output back into the capture path.
module codec_intf
  import codec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] lft_in,
  input  logic [DATA_W-1:0] rght_in,
  input  logic              SDout,
  output logic [DATA_W-1:0] lft_out,
  output logic [DATA_W-1:0] rght_out,
  output logic              vld,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              SDin,
  output logic              RSTn
);

  logic [CNT_W-1:0]    cnt_s;
  logic [4:0]          slot_s;
  logic                smpl_stb_s;
  logic                shft_stb_s;
  logic                frame_end_s;
  logic                rx_bit_s;
  logic                rx_en_s;
  logic                tx_en_s;
  logic                vld_set_s;
  logic [DATA_W-1:0]   rx_word_s;
  logic [DATA_W-1:0]   rx_shft_r;
  logic [DATA_W-1:0]   lft_hold_r;
  logic [DATA_W-1:0]   lft_out_r;
  logic [DATA_W-1:0]   rght_out_r;
  logic [2*DATA_W-1:0] tx_shft_r;
  logic                vld_r;
  logic                rstn_r;
  state_e              state_r;
  state_e              state_nxt_s;

  codec_clk_gen #(.CNT_W(CNT_W)) u_clk_gen (
    .clk       (clk),
    .rst       (rst),
    .cnt       (cnt_s),
    .slot      (slot_s),
    .mclk      (MCLK),
    .sclk      (SCLK),
    .lrclk     (LRCLK),
    .smpl_stb  (smpl_stb_s),
    .shft_stb  (shft_stb_s),
    .frame_end (frame_end_s)
  );

`ifdef CODEC_LOOPBACK_EN
  assign rx_bit_s = tx_shft_r[2*DATA_W-1];
`else
  assign rx_bit_s = SDout;
`endif

  assign rx_word_s = {rx_shft_r[DATA_W-2:0], rx_bit_s};
  assign rx_en_s   = smpl_stb_s && slot_in(slot_s, LAST_SLOT);
  // Right half needs only 15 shifts: its LSB is already on top for slot 16.
  assign tx_en_s   = shft_stb_s &&
                     slot_in(slot_s, cnt_s[CNT_W-1] ? (LAST_SLOT - 5'd1) : LAST_SLOT);
  assign vld_set_s = (state_r == ST_RUN) && (cnt_s == (VLD_CNT - 10'd1));

  // Startup sequencing: hold codec in reset one frame, settle one frame, then run.
  always_comb begin
    state_nxt_s = state_r;
    if (frame_end_s) begin
      case (state_r)
        ST_RST:  state_nxt_s = ST_SYNC;
        ST_SYNC: state_nxt_s = ST_RUN;
        ST_RUN:  state_nxt_s = ST_RUN;
        default: state_nxt_s = ST_RST;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register with registered codec reset and valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RST;
      rstn_r  <= 1'b0;
      vld_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rstn_r  <= (state_nxt_s != ST_RST);
      vld_r   <= vld_set_s;
    end
  end

  // Capture and serialize datapath; the pair is published as the right LSB arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shft_r  <= {DATA_W{1'b0}};
      lft_hold_r <= {DATA_W{1'b0}};
      lft_out_r  <= {DATA_W{1'b0}};
      rght_out_r <= {DATA_W{1'b0}};
      tx_shft_r  <= {(2*DATA_W){1'b0}};
    end else begin
      if (rx_en_s) begin
        rx_shft_r <= rx_word_s;
      end
      if (rx_en_s && (cnt_s == LFT_DONE)) begin
        lft_hold_r <= rx_word_s;
      end
      if (vld_set_s) begin
        lft_out_r  <= lft_hold_r;
        rght_out_r <= rx_word_s;
      end
      if (vld_r) begin
        tx_shft_r <= {lft_in, rght_in};
      end else if (tx_en_s) begin
        tx_shft_r <= {tx_shft_r[2*DATA_W-2:0], 1'b0};
      end
    end
  end

  assign lft_out  = lft_out_r;
  assign rght_out = rght_out_r;
  assign vld      = vld_r;
  assign SDin     = tx_shft_r[2*DATA_W-1];
  assign RSTn     = rstn_r;

endmodule

// File: tb/tb_codec_intf.sv
// Self-checking bench for codec_intf: frame-level codec model driving SDout and decoding SDin.
`timescale 1ns/1ps
module tb_codec_intf;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] lft_in, rght_in, lft_out, rght_out;
  logic        SDout, vld, MCLK, SCLK, LRCLK, SDin, RSTn;

  int n_checks = 0;
  int n_pass   = 0;

  int          cyc = 0;
  logic [15:0] cdc_l, cdc_r, nxt_l, nxt_r;
  logic [15:0] exp_lo, exp_ro;
  logic [15:0] dec_l, dec_r, done_l, done_r, done_exp_l, done_exp_r;
  logic [15:0] load_l, load_r, tx_exp_l, tx_exp_r;
  bit          frame_done;

  codec_intf dut (
    .clk(clk), .rst(rst), .lft_in(lft_in), .rght_in(rght_in), .SDout(SDout),
    .lft_out(lft_out), .rght_out(rght_out), .vld(vld), .MCLK(MCLK), .SCLK(SCLK),
    .LRCLK(LRCLK), .SDin(SDin), .RSTn(RSTn)
  );

  always #5 clk = ~clk;

  function automatic bit exp_vld(int c);
    return (c >= 2048) && (c % 1024 == 776);
  endfunction

  function automatic bit exp_rstn(int c);
    return c >= 1024;
  endfunction

  // Codec ADC model: MSB in slot 1, slot 16 = LSB, other slots carry noise.
  task automatic drive_sdout();
    int p, s;
    logic [15:0] w;
    p = cyc % 1024;
    s = (p % 512) / 16;
    w = (p >= 512) ? cdc_r : cdc_l;
`ifdef CODEC_LOOPBACK_EN
    SDout = 1'b0;
`else
    if (s >= 1 && s <= 16) SDout = w[16 - s];
    else SDout = 1'($urandom_range(1, 0));
`endif
  endtask

  task automatic tick();
    bit was_rst;
    int p, s;
    frame_done = 1'b0;
    was_rst = rst;
    if (!was_rst && exp_vld(cyc)) begin
      load_l = lft_in;
      load_r = rght_in;
    end
    if (!was_rst && (cyc % 1024 == 1023)) begin
      done_l = dec_l;       done_r = dec_r;
      done_exp_l = tx_exp_l; done_exp_r = tx_exp_r;
      tx_exp_l = load_l;    tx_exp_r = load_r;
      frame_done = 1'b1;
    end
    @(posedge clk);
    #1;
    if (was_rst) begin
      cyc = 0;
      load_l = 16'h0; load_r = 16'h0; tx_exp_l = 16'h0; tx_exp_r = 16'h0;
      dec_l = 16'h0; dec_r = 16'h0; exp_lo = 16'h0; exp_ro = 16'h0;
      cdc_l = nxt_l; cdc_r = nxt_r;
    end else begin
      cyc++;
    end
    p = cyc % 1024;
    s = (p % 512) / 16;
    if (!was_rst && p == 0) begin
      cdc_l = nxt_l;
      cdc_r = nxt_r;
    end
    if (exp_vld(cyc)) begin
`ifdef CODEC_LOOPBACK_EN
      exp_lo = tx_exp_l; exp_ro = tx_exp_r;
`else
      exp_lo = cdc_l; exp_ro = cdc_r;
`endif
    end
    if ((p % 16 == 7) && s >= 1 && s <= 16) begin
      if (p < 512) dec_l = {dec_l[14:0], SDin};
      else         dec_r = {dec_r[14:0], SDin};
    end
    drive_sdout();
  endtask

  task automatic test_reset();
    rst = 1'b1; lft_in = 16'h0; rght_in = 16'h0; SDout = 1'b0;
    nxt_l = 16'($urandom); nxt_r = 16'($urandom);
    repeat (3) tick();
    n_checks++;
    if ({MCLK, SCLK, LRCLK, SDin, RSTn, vld, lft_out, rght_out} !== 38'd0)
      $display("FAIL reset_values: got %h expected 0", {MCLK, SCLK, LRCLK, SDin, RSTn, vld, lft_out, rght_out});
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_startup();
    int first_vld = -1;
    while (cyc < 2830) begin
      lft_in = 16'($urandom); rght_in = 16'($urandom);
      tick();
      n_checks++;
      if (RSTn !== exp_rstn(cyc)) $display("FAIL startup_rstn: cyc=%0d got %b expected %b", cyc, RSTn, exp_rstn(cyc));
      else n_pass++;
      n_checks++;
      if (vld !== exp_vld(cyc)) $display("FAIL startup_vld: cyc=%0d got %b expected %b", cyc, vld, exp_vld(cyc));
      else n_pass++;
      n_checks++;
      if ({lft_out, rght_out} !== {exp_lo, exp_ro})
        $display("FAIL startup_out: cyc=%0d got %h expected %h", cyc, {lft_out, rght_out}, {exp_lo, exp_ro});
      else n_pass++;
      if (cyc <= 2824) begin
        n_checks++;
        if (SDin !== 1'b0) $display("FAIL startup_sdin: cyc=%0d got %b expected 0", cyc, SDin);
        else n_pass++;
      end
      if (vld === 1'b1 && first_vld < 0) first_vld = cyc;
    end
    n_checks++;
    if (first_vld !== 2824) $display("FAIL first_vld: got cycle %0d expected 2824", first_vld);
    else n_pass++;
  endtask

  task automatic test_clocks();
    logic [2:0] prev, cur;
    int last_rise[3];
    int per[3];
    per = '{4, 16, 1024};
    last_rise = '{-1, -1, -1};
    prev = {LRCLK, SCLK, MCLK};
    repeat (2100) begin
      tick();
      cur = {LRCLK, SCLK, MCLK};
      for (int i = 0; i < 3; i++) begin
        if (cur[i] && !prev[i]) begin
          if (last_rise[i] >= 0) begin
            n_checks++;
            if (cyc - last_rise[i] != per[i])
              $display("FAIL clk_period[%0d]: got %0d expected %0d", i, cyc - last_rise[i], per[i]);
            else n_pass++;
          end
          last_rise[i] = cyc;
        end else if (!cur[i] && prev[i] && last_rise[i] >= 0) begin
          n_checks++;
          if (cyc - last_rise[i] != per[i] / 2)
            $display("FAIL clk_high[%0d]: got %0d expected %0d", i, cyc - last_rise[i], per[i] / 2);
          else n_pass++;
        end
      end
      n_checks++;
      if (LRCLK !== ((cyc % 1024) >= 512))
        $display("FAIL lrclk_phase: cyc=%0d got %b expected %b", cyc, LRCLK, (cyc % 1024) >= 512);
      else n_pass++;
      prev = cur;
    end
  endtask

  task automatic test_rx_fixed();
    bit hit = 1'b0;
    nxt_l = 16'hA5C3; nxt_r = 16'h0F0F;
    for (int i = 0; i < 2200; i++) begin
      tick();
      n_checks++;
      if (vld !== exp_vld(cyc)) $display("FAIL rx_vld: cyc=%0d got %b expected %b", cyc, vld, exp_vld(cyc));
      else n_pass++;
      if (exp_vld(cyc) && cdc_l == 16'hA5C3 && cdc_r == 16'h0F0F) begin
        hit = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!hit) $display("FAIL rx_fixed_timeout: got no vld expected one within 2200 cycles");
    else n_pass++;
    n_checks++;
    if (lft_out !== 16'hA5C3) $display("FAIL rx_fixed_lft: got %h expected a5c3", lft_out);
    else n_pass++;
    n_checks++;
    if (rght_out !== 16'h0F0F) $display("FAIL rx_fixed_rght: got %h expected 0f0f", rght_out);
    else n_pass++;
    tick();
    n_checks++;
    if (vld !== 1'b0) $display("FAIL vld_width: got %b expected 0", vld);
    else n_pass++;
  endtask

  task automatic test_rx_random();
    int last_vld = -1;
    repeat (4096) begin
      if (cyc % 1024 == 1000) begin
        nxt_l = 16'($urandom); nxt_r = 16'($urandom);
      end
      lft_in = 16'($urandom); rght_in = 16'($urandom);
      tick();
      n_checks++;
      if (vld !== exp_vld(cyc)) $display("FAIL rxr_vld: cyc=%0d got %b expected %b", cyc, vld, exp_vld(cyc));
      else n_pass++;
      n_checks++;
      if ({lft_out, rght_out} !== {exp_lo, exp_ro})
        $display("FAIL rxr_out: cyc=%0d got %h expected %h", cyc, {lft_out, rght_out}, {exp_lo, exp_ro});
      else n_pass++;
      if (vld === 1'b1) begin
        if (last_vld >= 0) begin
          n_checks++;
          if (cyc - last_vld != 1024) $display("FAIL vld_period: got %0d expected 1024", cyc - last_vld);
          else n_pass++;
        end
        last_vld = cyc;
      end
    end
  endtask

  task automatic test_tx_fixed();
    lft_in = 16'h8001; rght_in = 16'h7FFE;
    repeat (3100) begin
      tick();
      if (frame_done) begin
        n_checks++;
        if ({done_l, done_r} !== {done_exp_l, done_exp_r})
          $display("FAIL tx_fixed_frame: got %h expected %h", {done_l, done_r}, {done_exp_l, done_exp_r});
        else n_pass++;
      end
    end
    n_checks++;
    if (done_l !== 16'h8001) $display("FAIL tx_fixed_lft: got %h expected 8001", done_l);
    else n_pass++;
    n_checks++;
    if (done_r !== 16'h7FFE) $display("FAIL tx_fixed_rght: got %h expected 7ffe", done_r);
    else n_pass++;
  endtask

  task automatic test_tx_random();
    repeat (4096) begin
      lft_in = 16'($urandom); rght_in = 16'($urandom);
      tick();
      if (frame_done) begin
        n_checks++;
        if ({done_l, done_r} !== {done_exp_l, done_exp_r})
          $display("FAIL tx_random_frame: got %h expected %h", {done_l, done_r}, {done_exp_l, done_exp_r});
        else n_pass++;
      end
    end
  endtask

  task automatic test_mid_reset();
    bit hit = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (cyc % 1024 == 400) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!hit || cyc < 2048) $display("FAIL mid_reset_reach: got cyc %0d expected cnt 400 in run", cyc);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (RSTn !== 1'b0) $display("FAIL mid_reset_rstn: got %b expected 0", RSTn);
    else n_pass++;
    n_checks++;
    if (SCLK !== 1'b0) $display("FAIL mid_reset_sclk: got %b expected 0", SCLK);
    else n_pass++;
    n_checks++;
    if (vld !== 1'b0) $display("FAIL mid_reset_vld: got %b expected 0", vld);
    else n_pass++;
    n_checks++;
    if ({lft_out, rght_out} !== 32'h0) $display("FAIL mid_reset_out: got %h expected 0", {lft_out, rght_out});
    else n_pass++;
    test_startup();
  endtask

`ifdef CODEC_LOOPBACK_EN
  task automatic test_loopback();
    int n = 0;
    lft_in = 16'h1234; rght_in = 16'hFEDC;
    for (int i = 0; i < 2200; i++) begin
      tick();
      if (vld === 1'b1) n++;
      if (n == 2) break;
    end
    n_checks++;
    if (n != 2) $display("FAIL loopback_timeout: got %0d vld expected 2", n);
    else n_pass++;
    n_checks++;
    if ({lft_out, rght_out} !== 32'h1234FEDC) $display("FAIL loopback_out: got %h expected 1234fedc", {lft_out, rght_out});
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_clocks();
`ifdef CODEC_LOOPBACK_EN
    test_loopback();
`else
    test_rx_fixed();
`endif
    test_rx_random();
    test_tx_fixed();
    test_tx_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
